// File: rtl/bcd_pkg.sv
// Shared constants, digit type and controller state encoding for the digit-serial BCD adder.
package bcd_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam logic [3:0]  BCD_MAX     = 4'd9;
   localparam logic [3:0]  BCD_ADJ     = 4'd6;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/bcd_digit_slice.sv
// Combinational one-digit BCD adder: d/co = a + b + ci with decimal adjust.
// Digits above 9 are not corrected; they simply flow through the same formula.
module bcd_digit_slice
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] d,
   output logic       co
);

   logic [4:0] z;

   // Binary sum, decimal carry decision and +6 adjust on overflow past 9.
   always_comb begin
      z  = 5'(a) + 5'(b) + 5'(ci);
      co = (z > 5'(BCD_MAX));
      d  = co ? 4'(z + 5'(BCD_ADJ)) : z[3:0];
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder sequencer: one shared digit slice, LSD first,
// valid/ready handshake on both the operand and result sides.
// Optional feature macro: BCD_DIGIT_CHECK_EN (flags operand digits above 9 on err).
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [4*DIGITS-1:0]          x,
   input  logic [4*DIGITS-1:0]          y,
   input  logic                         cin,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [4*DIGITS-1:0]          s,
   output logic                         cout,
   output logic                         busy,
   output logic                         err
);

   localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = $clog2(DIGITS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

   ctrl_state_t      state_q;
   logic [W-1:0]     x_sh_q;
   logic [W-1:0]     y_sh_q;
   logic [W-1:0]     s_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   bcd_digit_t       slice_d;
   logic             slice_co;

   bcd_digit_slice u_slice (
      .a  (x_sh_q[BCD_DIGIT_W-1:0]),
      .b  (y_sh_q[BCD_DIGIT_W-1:0]),
      .ci (carry_q),
      .d  (slice_d),
      .co (slice_co)
   );

`ifdef BCD_DIGIT_CHECK_EN
   logic err_q;

   // True when any packed digit of v exceeds 9.
   function automatic logic any_invalid(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) bad = 1'b1;
      end
      return bad;
   endfunction
`endif

   // Sequencer: capture, one digit per RUN cycle, hold result in DONE until taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_sh_q      <= '0;
         y_sh_q      <= '0;
         s_q         <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  x_sh_q     <= x;
                  y_sh_q     <= y;
                  carry_q    <= cin;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
`ifdef BCD_DIGIT_CHECK_EN
                  err_q      <= any_invalid(x) | any_invalid(y);
`endif
               end
            end
            RUN: begin
               x_sh_q  <= W'(x_sh_q >> BCD_DIGIT_W);
               y_sh_q  <= W'(y_sh_q >> BCD_DIGIT_W);
               s_q     <= W'({slice_d, s_q} >> BCD_DIGIT_W);
               carry_q <= slice_co;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  cout_q      <= slice_co;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign busy      = busy_q;
`ifdef BCD_DIGIT_CHECK_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule
